// File: rtl/axis_split_router_pkg.sv
// Shared definitions for the 3-port AXI4-Stream split router.
// Contains the route field width, the drop route code and the FSM state encoding.
package axis_split_router_pkg;

  localparam int ROUTE_W = 2;

  // Route code that marks a frame to be consumed and counted, not forwarded.
  localparam logic [ROUTE_W-1:0] ROUTE_DROP = 2'd3;

  typedef enum logic [1:0] {
    SOF  = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

endpackage

// File: rtl/axis_split_router_3_skid_reg.sv
// axis_skid_reg: 2-entry registered skid buffer (output register + one skid entry).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  write side; the writer only writes while skid_empty=1
//   skid_empty      skid entry free; this is the write-side ready (registered only)
//   out_valid/out_data/out_ready  read side, AXI-style handshake
module axis_skid_reg #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         skid_empty,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         pop;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    pop          = out_valid_q & out_ready;
    if (skid_valid_q) begin
      // Skid full: no write can arrive; a read refills the output from the skid.
      if (pop) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (wr_en) begin
      if (!out_valid_q || pop) begin
        out_valid_d = 1'b1;
        out_data_d  = wr_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = wr_data;
      end
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign skid_empty = ~skid_valid_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

endmodule

// File: rtl/axis_split_router_3.sv
// axis_split_router_3: steers whole AXI4-Stream frames to one of three outputs
// using the 2-bit route field of the first beat; route 3 frames are dropped and counted.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   s_axis_*                    input stream (tvalid/tdata/tlast/tready)
//   m00/m01/m02_axis_*          output streams, each behind a 2-entry skid buffer
//   drop_count                  saturating count of dropped frames
//
// state | meaning
// SOF   | waiting for the first beat of a frame; route decoded from s_axis_tdata
// FWD   | forwarding the rest of the frame to port sel_q
// DROP  | discarding the rest of a route-3 frame
module axis_split_router_3
  import axis_split_router_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ROUTE_LSB  = 60,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready,
  output logic                  m01_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m01_axis_tdata,
  output logic                  m01_axis_tlast,
  input  logic                  m01_axis_tready,
  output logic                  m02_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m02_axis_tdata,
  output logic                  m02_axis_tlast,
  input  logic                  m02_axis_tready,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  state_e               state_q, state_d;
  logic [ROUTE_W-1:0]   sel_q, sel_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic [ROUTE_W-1:0]   route;
  logic [ROUTE_W-1:0]   tgt;
  logic [3:0]           port_free;
  logic [2:0]           skid_empty;
  logic [2:0]           wr_en;
  logic [2:0]           m_valid, m_ready;
  logic [DATA_WIDTH:0]  m_pay [3];
  logic                 accept, fwd_ok;

  assign route = s_axis_tdata[ROUTE_LSB +: ROUTE_W];
  // Index 3 is the drop route, which can always accept.
  assign port_free = {1'b1, skid_empty};
  assign accept    = s_axis_tvalid & s_axis_tready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SOF;
      sel_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic drop_inc;
    state_d  = state_q;
    sel_d    = sel_q;
    drop_d   = drop_q;
    drop_inc = 1'b0;
    if (accept) begin
      case (state_q)
        SOF: begin
          if (route == ROUTE_DROP) begin
            if (s_axis_tlast) drop_inc = 1'b1;
            else              state_d  = DROP;
          end else begin
            sel_d = route;
            if (!s_axis_tlast) state_d = FWD;
          end
        end
        FWD: begin
          if (s_axis_tlast) state_d = SOF;
        end
        DROP: begin
          if (s_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = SOF;
          end
        end
        default: state_d = SOF;
      endcase
    end
    if (drop_inc && (drop_q != {CNT_WIDTH{1'b1}})) drop_d = drop_q + 1'b1;
  end

  // Output logic: input ready and per-port write enables
  always_comb begin
    s_axis_tready = 1'b0;
    tgt           = sel_q;
    fwd_ok        = 1'b0;
    case (state_q)
      SOF: begin
        s_axis_tready = port_free[route];
        tgt           = route;
        fwd_ok        = (route != ROUTE_DROP);
      end
      FWD: begin
        s_axis_tready = port_free[sel_q];
        fwd_ok        = 1'b1;
      end
      DROP: s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
    wr_en[0] = accept & fwd_ok & (tgt == 2'd0);
    wr_en[1] = accept & fwd_ok & (tgt == 2'd1);
    wr_en[2] = accept & fwd_ok & (tgt == 2'd2);
  end

  assign m_ready = {m02_axis_tready, m01_axis_tready, m00_axis_tready};

  for (genvar p = 0; p < 3; p++) begin : g_port
    axis_skid_reg #(.W(DATA_WIDTH + 1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en[p]),
      .wr_data   ({s_axis_tlast, s_axis_tdata}),
      .skid_empty(skid_empty[p]),
      .out_valid (m_valid[p]),
      .out_data  (m_pay[p]),
      .out_ready (m_ready[p])
    );
  end

  assign m00_axis_tvalid = m_valid[0];
  assign m00_axis_tlast  = m_pay[0][DATA_WIDTH];
  assign m00_axis_tdata  = m_pay[0][DATA_WIDTH-1:0];
  assign m01_axis_tvalid = m_valid[1];
  assign m01_axis_tlast  = m_pay[1][DATA_WIDTH];
  assign m01_axis_tdata  = m_pay[1][DATA_WIDTH-1:0];
  assign m02_axis_tvalid = m_valid[2];
  assign m02_axis_tlast  = m_pay[2][DATA_WIDTH];
  assign m02_axis_tdata  = m_pay[2][DATA_WIDTH-1:0];
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_axis_split_router_3.sv
module tb_axis_split_router_3;

  localparam int DW = 64;
  localparam int RL = 60;

  typedef logic [DW:0] beat_t;  // {last, data}

  typedef struct {
    int route;
    int len;
    int exp_port;
    int exp_beats;
    int exp_drop;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          s_valid, s_last, s_ready;
  logic [DW-1:0] s_data;
  logic [2:0]    mv, mr, ml;
  logic [DW-1:0] md [3];
  logic [15:0]   drop;

  logic          d2_valid, d2_last, d2_ready;
  logic [DW-1:0] d2_data;
  logic [2:0]    d2_mv, d2_ml;
  logic [DW-1:0] d2_md [3];
  logic [1:0]    d2_cnt;

  axis_split_router_3 #(.DATA_WIDTH(DW), .ROUTE_LSB(RL), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m00_axis_tvalid(mv[0]), .m00_axis_tdata(md[0]), .m00_axis_tlast(ml[0]), .m00_axis_tready(mr[0]),
    .m01_axis_tvalid(mv[1]), .m01_axis_tdata(md[1]), .m01_axis_tlast(ml[1]), .m01_axis_tready(mr[1]),
    .m02_axis_tvalid(mv[2]), .m02_axis_tdata(md[2]), .m02_axis_tlast(ml[2]), .m02_axis_tready(mr[2]),
    .drop_count(drop)
  );

  axis_split_router_3 #(.DATA_WIDTH(DW), .ROUTE_LSB(RL), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(d2_valid), .s_axis_tdata(d2_data), .s_axis_tlast(d2_last), .s_axis_tready(d2_ready),
    .m00_axis_tvalid(d2_mv[0]), .m00_axis_tdata(d2_md[0]), .m00_axis_tlast(d2_ml[0]), .m00_axis_tready(1'b1),
    .m01_axis_tvalid(d2_mv[1]), .m01_axis_tdata(d2_md[1]), .m01_axis_tlast(d2_ml[1]), .m01_axis_tready(1'b1),
    .m02_axis_tvalid(d2_mv[2]), .m02_axis_tdata(d2_md[2]), .m02_axis_tlast(d2_ml[2]), .m02_axis_tready(1'b1),
    .drop_count(d2_cnt)
  );

  int    checks = 0;
  int    errors = 0;
  int    exp_drop = 0;
  int    acc_cnt = 0;
  int    cyc = 0;
  int    em_cnt [3];
  int    rdy_mode [3];  // 0 = low, 1 = high, 2 = random 50%
  bit    vrand = 1'b0;
  bit    acc_pend = 1'b0;
  bit    held [3];
  beat_t hval [3];
  beat_t tx_q [$];
  beat_t exp_q [3][$];
  int    acc_cyc [$];
  vec_t  tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is a list of beats; the destination is fixed by
  // the route code of its first beat.
  task automatic add_frame(input int route, input int len);
    logic [DW-1:0] d;
    logic [1:0]    r;
    r = route[1:0];
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) d[RL +: 2] = r;
      tx_q.push_back({(i == len - 1), d});
      if (route < 3) exp_q[route].push_back({(i == len - 1), d});
    end
    if (route == 3) exp_drop++;
  endtask

  task automatic clear_model();
    tx_q.delete();
    for (int p = 0; p < 3; p++) begin
      exp_q[p].delete();
      held[p] = 1'b0;
      em_cnt[p] = 0;
    end
    acc_pend = 1'b0;
    exp_drop = 0;
  endtask

  task automatic run(input int max_cyc, input bit must_finish);
    int    n = 0;
    bit    done = 1'b0;
    beat_t e;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      if (acc_pend) begin
        void'(tx_q.pop_front());
        acc_pend = 1'b0;
        s_valid  = 1'b0;
      end
      for (int p = 0; p < 3; p++)
        mr[p] = (rdy_mode[p] == 2) ? 1'($urandom_range(1)) : (rdy_mode[p] == 1);
      if (!s_valid && tx_q.size() > 0 && (!vrand || $urandom_range(1) == 1)) begin
        s_valid = 1'b1;
        {s_last, s_data} = tx_q[0];
      end
      #1;
      for (int p = 0; p < 3; p++) begin
        if (held[p]) begin
          chk("hold_valid", 64'(mv[p]), 64'd1);
          chk("hold_data", md[p], hval[p][DW-1:0]);
          chk("hold_last", 64'(ml[p]), 64'(hval[p][DW]));
        end
        held[p] = mv[p] & ~mr[p];
        hval[p] = {ml[p], md[p]};
        if (mv[p] && mr[p]) begin
          em_cnt[p]++;
          if (exp_q[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat port=%0d actual=%0h required=none", p, md[p]);
          end else begin
            e = exp_q[p].pop_front();
            chk($sformatf("port%0d_data", p), md[p], e[DW-1:0]);
            chk($sformatf("port%0d_last", p), 64'(ml[p]), 64'(e[DW]));
          end
        end
      end
      if (s_valid && s_ready) begin
        acc_pend = 1'b1;
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
      cyc++;
      n++;
      done = (tx_q.size() == (acc_pend ? 1 : 0)) && exp_q[0].size() == 0 &&
             exp_q[1].size() == 0 && exp_q[2].size() == 0;
    end
    if (must_finish && !done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=%0d_cycles required=completion", n);
    end
    @(negedge clk);
    if (acc_pend) begin
      void'(tx_q.pop_front());
      acc_pend = 1'b0;
      s_valid  = 1'b0;
    end
    mr = 3'b000;
    #1;
    for (int p = 0; p < 3; p++) begin
      held[p] = mv[p];
      hval[p] = {ml[p], md[p]};
    end
  endtask

  initial begin
    logic [DW-1:0] b [4];
    logic [DW-1:0] a0;

    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    d2_valid = 1'b0; d2_last = 1'b0; d2_data = '0;
    mr = 3'b111;
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    // reset state
    chk("rst_valid", 64'(mv), 64'd0);
    chk("rst_last", 64'(ml), 64'd0);
    for (int p = 0; p < 3; p++) chk("rst_data", md[p], 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    chk("rst_drop2", 64'(d2_cnt), 64'd0);

    // 4-beat frame to port 1, all outputs ready
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    b[0][RL +: 2] = 2'd1;
    mr = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        s_valid = 1'b1; s_last = (i == 3); s_data = b[i];
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      #1;
      if (i < 4) chk("t1_ready", 64'(s_ready), 64'd1);
      if (i >= 1 && i <= 4) begin
        chk("t1_valid", 64'(mv[1]), 64'd1);
        chk("t1_data", md[1], b[i-1]);
        chk("t1_last", 64'(ml[1]), 64'(i == 4));
      end else begin
        chk("t1_idle1", 64'(mv[1]), 64'd0);
      end
      chk("t1_idle0", 64'(mv[0]), 64'd0);
      chk("t1_idle2", 64'(mv[2]), 64'd0);
    end

    // table of single frames, all outputs ready
    tbl[0] = '{0, 1, 0, 1, 0};
    tbl[1] = '{1, 4, 1, 4, 0};
    tbl[2] = '{2, 2, 2, 2, 0};
    tbl[3] = '{3, 1, 3, 0, 1};
    tbl[4] = '{3, 3, 3, 0, 2};
    tbl[5] = '{0, 8, 0, 8, 2};
    tbl[6] = '{2, 1, 2, 1, 2};
    tbl[7] = '{3, 2, 3, 0, 3};
    rdy_mode = '{1, 1, 1};
    vrand = 1'b0;
    held = '{0, 0, 0};
    for (int v = 0; v < 8; v++) begin
      em_cnt = '{0, 0, 0};
      add_frame(tbl[v].route, tbl[v].len);
      run(200, 1'b1);
      for (int p = 0; p < 3; p++)
        chk($sformatf("tbl%0d_beats_p%0d", v, p), 64'(em_cnt[p]),
            64'((p == tbl[v].exp_port) ? tbl[v].exp_beats : 0));
      chk($sformatf("tbl%0d_drop", v), 64'(drop), 64'(tbl[v].exp_drop));
    end

    // port 0 blocked: input stalls after two beats, beat 1 held
    rdy_mode = '{0, 1, 1};
    acc_cnt = 0;
    add_frame(0, 3);
    add_frame(2, 2);
    a0 = tx_q[0][DW-1:0];
    run(6, 1'b0);
    chk("t2_accepted", 64'(acc_cnt), 64'd2);
    chk("t2_hold_valid", 64'(mv[0]), 64'd1);
    chk("t2_hold_data", md[0], a0);
    chk("t2_stalled", 64'(s_ready), 64'd0);
    rdy_mode = '{1, 1, 1};
    run(100, 1'b1);

    // dropped 5-beat frame, then a single-beat frame to port 0
    em_cnt = '{0, 0, 0};
    acc_cyc.delete();
    add_frame(3, 5);
    add_frame(0, 1);
    run(100, 1'b1);
    chk("t3_accepts", 64'(acc_cyc.size()), 64'd6);
    if (acc_cyc.size() >= 5) chk("t3_back2back", 64'(acc_cyc[4] - acc_cyc[0]), 64'd4);
    chk("t3_drop", 64'(drop), 64'(exp_drop));
    chk("t3_em0", 64'(em_cnt[0]), 64'd1);
    chk("t3_em1", 64'(em_cnt[1]), 64'd0);
    chk("t3_em2", 64'(em_cnt[2]), 64'd0);

    // reset in the middle of a route-2 frame
    mr = 3'b000;
    @(negedge clk);
    s_valid = 1'b1; s_last = 1'b0; s_data = {$urandom, $urandom}; s_data[RL +: 2] = 2'd2;
    @(negedge clk);
    s_data = {$urandom, $urandom};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("t5_valid", 64'(mv), 64'd0);
    chk("t5_drop", 64'(drop), 64'd0);
    clear_model();
    rdy_mode = '{1, 1, 1};
    add_frame(1, 3);
    run(100, 1'b1);
    chk("t5_em1", 64'(em_cnt[1]), 64'd3);
    chk("t5_em2", 64'(em_cnt[2]), 64'd0);

    // random traffic
    rdy_mode = '{2, 2, 2};
    vrand = 1'b1;
    for (int f = 0; f < 200; f++) add_frame($urandom_range(3), $urandom_range(8, 1));
    run(40000, 1'b1);
    chk("t4_tx_empty", 64'(tx_q.size()), 64'd0);
    chk("t4_drop", 64'(drop), 64'(exp_drop));

    // drop counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) chk("t6_cnt", 64'(d2_cnt), 64'((i < 3) ? i : 3));
      d2_valid = 1'b1; d2_last = 1'b1; d2_data = {$urandom, $urandom}; d2_data[RL +: 2] = 2'd3;
      #1;
      chk("t6_ready", 64'(d2_ready), 64'd1);
    end
    @(negedge clk);
    d2_valid = 1'b0;
    #1;
    chk("t6_sat", 64'(d2_cnt), 64'd3);
    chk("t6_no_out", 64'(d2_mv), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
